// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with jump/branch redirect, stall hold and flush.
// Optional halt-on-16'hFFFF support (with the halted_out port) is enabled by defining FETCH_HALT_EN.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        stall_in,
    input  logic        jmp_in,
    input  logic [7:0]  jtarget_in,
    input  logic        bne_taken_in,
    input  logic [4:0]  boffset_in,
    input  logic [31:0] PC_br_in,
    output logic [15:0] instr_out,
    output logic [31:0] PC_out,
    output logic        valid_out
`ifdef FETCH_HALT_EN
    ,
    output logic        halted_out
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic        req_r, req_nxt_s;
    logic [31:0] addr_r, addr_nxt_s;
    logic [15:0] instr_r, instr_nxt_s;
    logic [31:0] pc_out_r, pc_out_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        halted_r, halted_nxt_s;
    logic        redirect_s;
    logic        halt_hit_s;
    logic [31:0] target_s;

    function automatic logic [31:0] branch_target(input logic [31:0] pc_br, input logic [4:0] offset);
        return pc_br + 32'd1 + {{27{offset[4]}}, offset};
    endfunction

    // Jump wins over a simultaneous taken branch; redirects are dropped once halted.
    assign redirect_s = (jmp_in | bne_taken_in) & ~halted_r;
    assign target_s   = jmp_in ? {PC_br_in[31:8], jtarget_in} : branch_target(PC_br_in, boffset_in);

`ifdef FETCH_HALT_EN
    assign halt_hit_s = (imem_data == 16'hFFFF);
    assign halted_out = halted_r;
`else
    assign halt_hit_s = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        instr_nxt_s  = instr_r;
        pc_out_nxt_s = pc_out_r;
        valid_nxt_s  = valid_r & stall_in;
        halted_nxt_s = halted_r;
        req_nxt_s    = 1'b0;
        addr_nxt_s   = addr_r;
        case (state_r)
            IDLE: begin
                if (redirect_s) begin
                    pc_nxt_s = target_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
                state_nxt_s = REQ;
            end
            REQ: begin
                if (redirect_s) begin
                    pc_nxt_s    = target_s;
                    valid_nxt_s = 1'b0;
                    state_nxt_s = imem_ack ? REQ : FLUSH;
                end else if (imem_ack) begin
                    instr_nxt_s  = imem_data;
                    pc_out_nxt_s = pc_r;
                    valid_nxt_s  = 1'b1;
                    pc_nxt_s     = pc_r + 32'd1;
                    halted_nxt_s = halt_hit_s;
                    state_nxt_s  = (stall_in | halt_hit_s) ? HOLD : REQ;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            HOLD: begin
                if (halted_r) begin
                    state_nxt_s = HOLD;
                end else if (redirect_s) begin
                    pc_nxt_s    = target_s;
                    valid_nxt_s = 1'b0;
                    state_nxt_s = REQ;
                end else if (!stall_in) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            FLUSH: begin
                // The stale request must still complete; its data is dropped.
                if (redirect_s) begin
                    pc_nxt_s    = target_s;
                    valid_nxt_s = 1'b0;
                    state_nxt_s = imem_ack ? REQ : FLUSH;
                end else if (imem_ack) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        req_nxt_s = (state_nxt_s == REQ) || (state_nxt_s == FLUSH);
        if (state_nxt_s == FLUSH) begin
            addr_nxt_s = addr_r;
        end else begin
            addr_nxt_s = pc_nxt_s;
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            pc_r     <= 32'd0;
            req_r    <= 1'b0;
            addr_r   <= 32'd0;
            instr_r  <= 16'd0;
            pc_out_r <= 32'd0;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            req_r    <= req_nxt_s;
            addr_r   <= addr_nxt_s;
            instr_r  <= instr_nxt_s;
            pc_out_r <= pc_out_nxt_s;
            valid_r  <= valid_nxt_s;
            halted_r <= halted_nxt_s;
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = addr_r;
    assign instr_out = instr_r;
    assign PC_out    = pc_out_r;
    assign valid_out = valid_r;

endmodule
